// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan: digit codes, decimal points and load/blank
// controls going in, shared segment bus and digit enables coming out.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] sin;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                blank_lz;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   com;

  modport master (output sin, dp_in, load, blank_lz, input seg, com);
  modport slave  (input sin, dp_in, load, blank_lz, output seg, com);
endinterface

// File: rtl/seg_scan.sv
// Multiplexed N-digit 7-segment scanner with hex decode, per-digit dp,
// leading-zero suppression and frame-boundary (tear-free) value updates.
module seg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int HEX    = 1
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave io
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d, frame_q, frame_d;
  logic [DIGITS-1:0]   pdp_q, pdp_d, fdp_q, fdp_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   com_q, com_d;
  logic                tick, wrap;
  logic [DIGITS-1:0]   lz;
  logic [3:0]          code;
  logic                dp_sel, blank;

  function automatic logic [6:0] dec7(input logic [3:0] c);
    logic [6:0] r;
    case (c)
      4'h0: r = 7'b1111110;
      4'h1: r = 7'b0110000;
      4'h2: r = 7'b1101101;
      4'h3: r = 7'b1111001;
      4'h4: r = 7'b0110011;
      4'h5: r = 7'b1011011;
      4'h6: r = 7'b1011111;
      4'h7: r = 7'b1110000;
      4'h8: r = 7'b1111111;
      4'h9: r = 7'b1111011;
      4'hA: r = (HEX != 0) ? 7'b1110111 : 7'b0000000;
      4'hB: r = (HEX != 0) ? 7'b0011111 : 7'b0000000;
      4'hC: r = (HEX != 0) ? 7'b1001110 : 7'b0000000;
      4'hD: r = (HEX != 0) ? 7'b0111101 : 7'b0000000;
      4'hE: r = (HEX != 0) ? 7'b1001111 : 7'b0000000;
      default: r = (HEX != 0) ? 7'b1000111 : 7'b0000000;
    endcase
    return r;
  endfunction

  always_comb begin
    tick  = (div_q == DIV_LAST);
    wrap  = tick && (idx_q == IDX_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    pend_d = io.load ? io.sin : pend_q;
    pdp_d  = io.load ? io.dp_in : pdp_q;
    // Frame only moves at the wrap; a load in that same cycle bypasses pending.
    frame_d = frame_q;
    fdp_d   = fdp_q;
    if (wrap) begin
      frame_d = io.load ? io.sin : pend_q;
      fdp_d   = io.load ? io.dp_in : pdp_q;
    end
  end

  always_comb begin
    lz = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      for (int unsigned j = i; j < DIGITS; j++) begin
        if (frame_q[4*j +: 4] != 4'd0) lz[i] = 1'b0;
      end
    end
  end

  always_comb begin
    code   = '0;
    dp_sel = 1'b0;
    blank  = 1'b0;
    com_d  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        code     = frame_q[4*i +: 4];
        dp_sel   = fdp_q[i];
        blank    = io.blank_lz && lz[i] && (i != 0);
        com_d[i] = 1'b1;
      end
    end
    seg_d = {(blank ? 7'b0000000 : dec7(code)), dp_sel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      pdp_q   <= '0;
      frame_q <= '0;
      fdp_q   <= '0;
      seg_q   <= '0;
      com_q   <= '0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      frame_q <= frame_d;
      fdp_q   <= fdp_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
    end
  end

  assign io.seg = seg_q;
  assign io.com = com_q;
endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan (DIGITS=4, DIV=4): a HEX=1 and a HEX=0 instance
// share stimulus; expected com/seg per checked cycle are queued by the stimulus.
module tb_seg_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_scan_if #(.DIGITS(4)) bus_h ();
  seg_scan_if #(.DIGITS(4)) bus_n ();

  assign bus_n.sin      = bus_h.sin;
  assign bus_n.dp_in    = bus_h.dp_in;
  assign bus_n.load     = bus_h.load;
  assign bus_n.blank_lz = bus_h.blank_lz;

  seg_scan #(.DIGITS(4), .DIV(4), .HEX(1)) dut_h (.clk(clk), .rst(rst), .io(bus_h));
  seg_scan #(.DIGITS(4), .DIV(4), .HEX(0)) dut_n (.clk(clk), .rst(rst), .io(bus_n));

  typedef struct {
    int         cyc;
    logic [3:0] com;
    logic [7:0] s_hex;
    logic [7:0] s_nohex;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // t is relative to the first edge with rst low (global edge 4).
  task automatic expect_at(input int t, input logic [3:0] com, input logic [7:0] sh,
                           input logic [7:0] sn, input string name);
    exp_t x;
    x.cyc = 4 + t; x.com = com; x.s_hex = sh; x.s_nohex = sn; x.name = name;
    sb.push_back(x);
  endtask

  task automatic goto(input int t);
    while (cyc < 3 + t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, req);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      $display("FAIL %s: not sampled, expected at cyc %0d, now %0d", e.name, e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk({e.name, ".com"},     {4'b0000, bus_h.com}, {4'b0000, e.com});
      chk({e.name, ".seg_hex"}, bus_h.seg,            e.s_hex);
      chk({e.name, ".seg_nohex"}, bus_n.seg,          e.s_nohex);
    end
  end

  initial begin
    bus_h.sin = '0; bus_h.dp_in = '0; bus_h.load = 1'b0; bus_h.blank_lz = 1'b0;
    expect_at(-2, 4'b0000, 8'h00, 8'h00, "rst_a");
    expect_at(-1, 4'b0000, 8'h00, 8'h00, "rst_b");
    expect_at(0,  4'b0001, 8'hFC, 8'hFC, "first");
    goto(0);
    rst = 1'b0;

    // 1234 loaded early in frame 0, shown from frame 1
    goto(1);
    bus_h.sin = 16'h1234; bus_h.load = 1'b1;
    expect_at(8,  4'b0100, 8'hFC, 8'hFC, "old_d2");
    expect_at(12, 4'b1000, 8'hFC, 8'hFC, "old_d3");
    expect_at(16, 4'b0001, 8'h66, 8'h66, "s1234_d0");
    expect_at(19, 4'b0001, 8'h66, 8'h66, "s1234_d0_end");
    expect_at(20, 4'b0010, 8'hF2, 8'hF2, "s1234_d1");
    expect_at(24, 4'b0100, 8'hDA, 8'hDA, "s1234_d2");
    expect_at(28, 4'b1000, 8'h60, 8'h60, "s1234_d3");
    expect_at(31, 4'b1000, 8'h60, 8'h60, "s1234_d3_end");
    expect_at(32, 4'b0001, 8'h66, 8'h66, "s1234_wrap");
    goto(2);
    bus_h.load = 1'b0;

    goto(33);
    bus_h.sin = 16'hABCD; bus_h.load = 1'b1;
    expect_at(48, 4'b0001, 8'h7A, 8'h00, "hex_d");
    expect_at(52, 4'b0010, 8'h9C, 8'h00, "hex_c");
    expect_at(56, 4'b0100, 8'h3E, 8'h00, "hex_b");
    expect_at(60, 4'b1000, 8'hEE, 8'h00, "hex_a");
    goto(34);
    bus_h.load = 1'b0;

    goto(49);
    bus_h.sin = 16'h0050; bus_h.dp_in = 4'b0100; bus_h.blank_lz = 1'b1; bus_h.load = 1'b1;
    expect_at(64, 4'b0001, 8'hFC, 8'hFC, "lz_d0");
    expect_at(68, 4'b0010, 8'hB6, 8'hB6, "lz_d1");
    expect_at(72, 4'b0100, 8'h01, 8'h01, "lz_d2_dp");
    goto(50);
    bus_h.load = 1'b0;
    goto(73);
    bus_h.blank_lz = 1'b0;
    expect_at(76, 4'b1000, 8'hFC, 8'hFC, "nolz_d3");
    expect_at(79, 4'b1000, 8'hFC, 8'hFC, "nolz_d3_end");

    // mid-frame load must not tear the frame in progress
    goto(85);
    bus_h.sin = 16'h1111; bus_h.dp_in = 4'b0000; bus_h.load = 1'b1;
    expect_at(88,  4'b0100, 8'hFD, 8'hFD, "tear_old_d2");
    expect_at(92,  4'b1000, 8'hFC, 8'hFC, "tear_old_d3");
    expect_at(96,  4'b0001, 8'h60, 8'h60, "tear_new_d0");
    expect_at(108, 4'b1000, 8'h60, 8'h60, "tear_new_d3");
    goto(86);
    bus_h.load = 1'b0;

    // load in the wrap cycle bypasses straight into the frame
    goto(111);
    bus_h.sin = 16'h2222; bus_h.dp_in = 4'b0001; bus_h.load = 1'b1;
    expect_at(112, 4'b0001, 8'hDB, 8'hDB, "bypass_d0");
    expect_at(116, 4'b0010, 8'hDA, 8'hDA, "bypass_d1");
    expect_at(124, 4'b1000, 8'hDA, 8'hDA, "bypass_d3");
    expect_at(136, 4'b0100, 8'hDA, 8'hDA, "pre_rst_d2");
    goto(112);
    bus_h.load = 1'b0;

    goto(137);
    rst = 1'b1;
    expect_at(137, 4'b0000, 8'h00, 8'h00, "midrst");
    goto(138);
    rst = 1'b0;
    expect_at(138, 4'b0001, 8'hFC, 8'hFC, "rst_restart_d0");
    expect_at(141, 4'b0001, 8'hFC, 8'hFC, "rst_restart_d0_end");
    expect_at(142, 4'b0010, 8'hFC, 8'hFC, "rst_restart_d1");

    goto(150);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      $display("FAIL %s: never sampled, expected at cyc %0d", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
